// File: rtl/mem_lsu.sv
// mem_lsu: memory stage between execute and write-back.
//
// Decodes the EX-stage operation. Non-memory ops pass to a registered
// write-back triple one cycle later. Loads and stores use a bus that
// allows one outstanding request and completes it with an ack.
// The pipeline stalls while that access is pending.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   ex_*_i            EX result, destination, opcode, address, store operand
//   flush_i           squash the current or pending operation
//   stallreq_o        combinational stall request to upstream stages
//   wdata_o/wd_o/wreg_o  registered write-back triple
//   misalign_o        one-cycle pulse: misaligned access rejected
//   bus_err_o         one-cycle pulse: bus access aborted on timeout
//   mem_*_o / mem_*_i data bus (req/ack, word address, big-endian lanes)
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_wdata_i,
    input  logic [4:0]  ex_wd_i,
    input  logic        ex_wreg_i,
    input  logic [7:0]  ex_aluop_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [31:0] ex_reg2_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUS  = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Byte-lane enables, big-endian: byte address 0 sits on bits [31:24].
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    lane_sel = 4'b1000 >> a;
            SZ_H:    lane_sel = a[1] ? 4'b0011 : 4'b1100;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    // Store operand replicated across all lanes so any lane select picks it up.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_B:    store_data = {4{d[7:0]}};
            SZ_H:    store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sext,
                                                 input logic [1:0] a, input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] bs;
        logic signed [31:0] hs;
        b  = rd[{~a, 3'b000} +: 8];
        h  = a[1] ? rd[15:0] : rd[31:16];
        bs = b;
        hs = h;
        case (size)
            SZ_B:    load_extract = sext ? bs : {24'b0, b};
            SZ_H:    load_extract = sext ? hs : {16'b0, h};
            default: load_extract = rd;
        endcase
    endfunction

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             squash_q, squash_d;
    logic             req_q, req_d, we_q, we_d;
    logic [31:0]      addr_q, addr_d, mwdata_q, mwdata_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [4:0]       wd_q, wd_d;
    logic             wreg_q, wreg_d, mis_q, mis_d, err_q, err_d;

    logic       is_mem, is_load, is_sext, misaligned, timeout_hit;
    logic [1:0] size;

    always_comb begin
        is_mem  = 1'b1;
        is_load = 1'b0;
        is_sext = 1'b0;
        size    = SZ_W;
        case (ex_aluop_i)
            8'hE0: begin is_load = 1'b1; is_sext = 1'b1; size = SZ_B; end
            8'hE4: begin is_load = 1'b1; size = SZ_B; end
            8'hE1: begin is_load = 1'b1; is_sext = 1'b1; size = SZ_H; end
            8'hE5: begin is_load = 1'b1; size = SZ_H; end
            8'hE3: begin is_load = 1'b1; size = SZ_W; end
            8'hE8: size = SZ_B;
            8'hE9: size = SZ_H;
            8'hEB: size = SZ_W;
            default: is_mem = 1'b0;
        endcase
        misaligned = ((size == SZ_H) && ex_mem_addr_i[0]) ||
                     ((size == SZ_W) && (ex_mem_addr_i[1:0] != 2'b00));
    end

    // Abort fires only when the last allowed cycle passes without an ack.
    assign timeout_hit = (state_q == S_BUS) && !mem_ack_i && (cnt_q == CNT_LAST);

    always_comb begin
        if (state_q == S_IDLE)
            stallreq_o = is_mem && !misaligned && !flush_i;
        else
            stallreq_o = !mem_ack_i && !timeout_hit;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        squash_d = squash_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        mwdata_d = mwdata_q;
        wdata_d  = wdata_q;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        mis_d    = 1'b0;
        err_d    = 1'b0;
        if (state_q == S_IDLE) begin
            wdata_d = ex_wdata_i;
            wd_d    = ex_wd_i;
            if (flush_i) begin
                wreg_d = 1'b0;
            end else if (!is_mem) begin
                wreg_d = ex_wreg_i;
            end else if (misaligned) begin
                wreg_d = 1'b0;
                mis_d  = 1'b1;
            end else begin
                req_d    = 1'b1;
                we_d     = !is_load;
                addr_d   = {ex_mem_addr_i[31:2], 2'b00};
                sel_d    = lane_sel(size, ex_mem_addr_i[1:0]);
                mwdata_d = store_data(size, ex_reg2_i);
                wreg_d   = 1'b0;
                cnt_d    = '0;
                state_d  = S_BUS;
            end
        end else begin
            if (flush_i)
                squash_d = 1'b1;
            // Upstream holds ex_* stable while stalled, so they still describe
            // the in-flight op on the ack cycle.
            if (mem_ack_i) begin
                req_d    = 1'b0;
                state_d  = S_IDLE;
                squash_d = 1'b0;
                wd_d     = ex_wd_i;
                wdata_d  = is_load ? load_extract(size, is_sext, ex_mem_addr_i[1:0], mem_rdata_i)
                                   : ex_wdata_i;
                wreg_d   = ex_wreg_i && !squash_q && !flush_i;
            end else if (timeout_hit) begin
                req_d    = 1'b0;
                state_d  = S_IDLE;
                squash_d = 1'b0;
                wreg_d   = 1'b0;
                err_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            squash_q <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            sel_q    <= '0;
            mwdata_q <= '0;
            wdata_q  <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            squash_q <= squash_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            mwdata_q <= mwdata_d;
            wdata_q  <= wdata_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
        end
    end

    assign wdata_o     = wdata_q;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign misalign_o  = mis_q;
    assign bus_err_o   = err_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_sel_o   = sel_q;
    assign mem_wdata_o = mwdata_q;

endmodule
